// File: rtl/matrix_load_sequencer.sv
// matrix_load_sequencer: streams operand blocks from a byte memory into the
// PADSTOP matrix core, honours the core's replay request, then sweeps the
// four result slots and emits each one on a strobed result stream.
module matrix_load_sequencer #(
    parameter  int BLOCK_LEN  = 32,
    parameter  int NUM_BLOCKS = 5,
    parameter  int ADDR_W     = 8,
    parameter  int READ_HOLD  = 2,
    localparam int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              core_start,
    output logic [7:0]        X_load,
    input  logic              input_load_en,
    input  logic              Xload_done,
    output logic [1:0]        P_sel,
    input  logic [8:0]        P_out,
    output logic              res_valid,
    output logic [8:0]        res_data,
    output logic [BLK_W-1:0]  res_block,
    output logic [1:0]        res_idx
);

    localparam int OFF_W  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int HOLD_W = (READ_HOLD > 1) ? $clog2(READ_HOLD) : 1;

    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(BLOCK_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READ_HOLD - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {IDLE, START, LOAD, READ, DONE} state_t;

    typedef struct packed {
        logic [8:0]       data;
        logic [BLK_W-1:0] blk;
        logic [1:0]       idx;
    } res_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base_ptr, base_nxt;
    logic [OFF_W-1:0]    offset, off_nxt;
    logic [BLK_W-1:0]    blk, blk_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [1:0]          psel_nxt;
    logic [7:0]          xload_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                cs_nxt;
    logic                rv_nxt;
    res_t                res_q, res_nxt;

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign res_data  = res_q.data;
    assign res_block = res_q.blk;
    assign res_idx   = res_q.idx;

    // Next-state and next-register values; mem_addr is precomputed so the
    // registered address always tracks base_ptr+offset with no lag.
    always_comb begin
        state_nxt = state;
        base_nxt  = base_ptr;
        off_nxt   = offset;
        blk_nxt   = blk;
        hold_nxt  = hold_cnt;
        psel_nxt  = P_sel;
        xload_nxt = X_load;
        rv_nxt    = 1'b0;
        res_nxt   = res_q;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = START;
                    base_nxt  = '0;
                    off_nxt   = '0;
                    blk_nxt   = '0;
                    hold_nxt  = '0;
                    psel_nxt  = '0;
                end
            end
            START: state_nxt = LOAD;
            LOAD: begin
                if (input_load_en) begin
                    // end-of-block wins over a coincident replay request
                    if (offset == OFF_LAST) begin
                        xload_nxt = mem_rdata;
                        off_nxt   = '0;
                        hold_nxt  = '0;
                        psel_nxt  = '0;
                        state_nxt = READ;
                    end else if (Xload_done) begin
                        off_nxt   = '0;
                    end else begin
                        xload_nxt = mem_rdata;
                        off_nxt   = offset + OFF_W'(1);
                    end
                end
            end
            READ: begin
                if (hold_cnt == HOLD_LAST) begin
                    rv_nxt       = 1'b1;
                    res_nxt.data = P_out;
                    res_nxt.blk  = blk;
                    res_nxt.idx  = P_sel;
                    hold_nxt     = '0;
                    psel_nxt     = P_sel + 2'd1;
                    if (P_sel == 2'd3) begin
                        if (blk == BLK_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            blk_nxt   = blk + BLK_W'(1);
                            base_nxt  = base_ptr + ADDR_W'(BLOCK_LEN);
                            state_nxt = LOAD;
                        end
                    end
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            DONE: begin
                xload_nxt = '0;
                if (!go) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // X_load and core_start already reflect DONE in its first cycle
        if (state_nxt == DONE) xload_nxt = '0;
        cs_nxt   = (state_nxt == START) || (state_nxt == LOAD) || (state_nxt == READ);
        addr_nxt = base_nxt + ADDR_W'(off_nxt);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_ptr   <= '0;
            offset     <= '0;
            blk        <= '0;
            hold_cnt   <= '0;
            P_sel      <= '0;
            X_load     <= '0;
            mem_addr   <= '0;
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            res_q      <= '0;
        end else begin
            state      <= state_nxt;
            base_ptr   <= base_nxt;
            offset     <= off_nxt;
            blk        <= blk_nxt;
            hold_cnt   <= hold_nxt;
            P_sel      <= psel_nxt;
            X_load     <= xload_nxt;
            mem_addr   <= addr_nxt;
            core_start <= cs_nxt;
            res_valid  <= rv_nxt;
            res_q      <= res_nxt;
        end
    end

endmodule
